// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control/status bundle for the multi-channel clock divider.
// The master drives enables, divisor loads and the sync strobe; the slave
// (the divider) returns the divided clocks, toggle ticks and pending flags.
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0] en;
  logic              load;
  logic [NUM_CH-1:0] load_mask;
  logic [CNT_W-1:0]  div_in;
  logic              sync;
  logic [NUM_CH-1:0] clk_d;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

  modport master (
    output en, load, load_mask, div_in, sync,
    input  clk_d, tick, pending
  );

  modport slave (
    input  en, load, load_mask, div_in, sync,
    output clk_d, tick, pending
  );
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock dividers.
// Each channel counts 0..div_act and toggles clk_d at the terminal count (TC),
// giving a half-period of div_act+1 cycles. A divisor loaded while running is
// held in a shadow register and only applied at TC, so no phase is ever cut
// short. Optional feature macro: CLKDIV_SYNC_EN (sync strobe phase-aligns all
// enabled channels); without it the sync input is present but unused.
module clk_div_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_div_multi_if.slave bus
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  act_q [NUM_CH];
  logic [CNT_W-1:0]  act_d [NUM_CH];
  logic [CNT_W-1:0]  sh_q  [NUM_CH];
  logic [CNT_W-1:0]  sh_d  [NUM_CH];
  logic [NUM_CH-1:0] clk_d_q, clk_d_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] tc_hit;
  logic [NUM_CH-1:0] ld_hit;

  assign ld_hit = {NUM_CH{bus.load}} & bus.load_mask;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_tc
    assign tc_hit[g] = (cnt_q[g] == act_q[g]);
  end

`ifndef CLKDIV_SYNC_EN
  // Sync strobe has no function in this build; tie it off to a named sink.
  logic unused_sync;
  assign unused_sync = bus.sync;
`endif

  // Next-state logic for every channel: count, toggle at TC, divisor handoff.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      act_d[i]   = act_q[i];
      sh_d[i]    = sh_q[i];
      clk_d_d[i] = clk_d_q[i];
      tick_d[i]  = 1'b0;
      pend_d[i]  = pend_q[i];
      if (bus.en[i]) begin
`ifdef CLKDIV_SYNC_EN
        if (bus.sync) begin
          // Phase restart: both counter and output begin a fresh low phase.
          cnt_d[i]   = '0;
          clk_d_d[i] = 1'b0;
          if (ld_hit[i]) begin
            act_d[i]  = bus.div_in;
            sh_d[i]   = bus.div_in;
            pend_d[i] = 1'b0;
          end else if (pend_q[i]) begin
            act_d[i]  = sh_q[i];
            pend_d[i] = 1'b0;
          end else begin
            act_d[i]  = act_q[i];
          end
        end else
`endif
        if (tc_hit[i]) begin
          cnt_d[i]   = '0;
          clk_d_d[i] = ~clk_d_q[i];
          tick_d[i]  = 1'b1;
          if (ld_hit[i]) begin
            // Load landing on TC takes effect for the very next half-period.
            act_d[i]  = bus.div_in;
            sh_d[i]   = bus.div_in;
            pend_d[i] = 1'b0;
          end else if (pend_q[i]) begin
            act_d[i]  = sh_q[i];
            pend_d[i] = 1'b0;
          end else begin
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + ONE_C;
          if (ld_hit[i]) begin
            // Defer to TC so the current half-period completes at old length.
            sh_d[i]   = bus.div_in;
            pend_d[i] = 1'b1;
          end else begin
            sh_d[i]   = sh_q[i];
          end
        end
      end else begin
        if (ld_hit[i]) begin
          // Stopped channel: no phase to protect, apply immediately.
          act_d[i]  = bus.div_in;
          sh_d[i]   = bus.div_in;
          cnt_d[i]  = '0;
          pend_d[i] = 1'b0;
        end else begin
          cnt_d[i]  = cnt_q[i];
        end
      end
    end
  end

  // State registers with synchronous active-low reset to DEF_DIV.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= DEF_DIV_C;
        sh_q[i]  <= DEF_DIV_C;
      end
      clk_d_q <= '0;
      tick_q  <= '0;
      pend_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
        sh_q[i]  <= sh_d[i];
      end
      clk_d_q <= clk_d_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.clk_d   = clk_d_q;
  assign bus.tick    = tick_q;
  assign bus.pending = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: directed scenarios plus randomized traffic,
// all compared against a countdown-style behavioural model of each channel.
module tb_clk_div_multi;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int DEF = 1;
`ifdef CLKDIV_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: per channel, enabled cycles remaining until the next toggle.
  int             m_rem [NCH];
  logic [CW-1:0]  m_act [NCH];
  logic [CW-1:0]  m_sh  [NCH];
  logic [NCH-1:0] m_clk, m_tick, m_pend;

  task automatic model_edge();
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_act[c] = CW'(DEF); m_sh[c] = CW'(DEF); m_rem[c] = DEF + 1;
      end
      m_clk = '0; m_tick = '0; m_pend = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        bit ld;
        ld = bus.load && bus.load_mask[c];
        m_tick[c] = 1'b0;
        if (!bus.en[c]) begin
          if (ld) begin
            m_act[c] = bus.div_in; m_sh[c] = bus.div_in;
            m_pend[c] = 1'b0; m_rem[c] = int'(bus.div_in) + 1;
          end
        end else if (SYNC_ON && bus.sync) begin
          m_clk[c] = 1'b0;
          if (ld) begin m_act[c] = bus.div_in; m_sh[c] = bus.div_in; end
          else if (m_pend[c]) m_act[c] = m_sh[c];
          m_pend[c] = 1'b0;
          m_rem[c] = int'(m_act[c]) + 1;
        end else begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            m_clk[c] = ~m_clk[c]; m_tick[c] = 1'b1;
            if (ld) begin m_act[c] = bus.div_in; m_sh[c] = bus.div_in; end
            else if (m_pend[c]) m_act[c] = m_sh[c];
            m_pend[c] = 1'b0;
            m_rem[c] = int'(m_act[c]) + 1;
          end else if (ld) begin
            m_sh[c] = bus.div_in; m_pend[c] = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: model updates from inputs at the edge, outputs sampled 1 later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.en = '0; bus.load = 1'b0; bus.load_mask = '0;
    bus.div_in = '0; bus.sync = 1'b0;
    step(); step();
    n_checks++;
    if ({bus.clk_d, bus.tick, bus.pending} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_outputs got %h want 000", {bus.clk_d, bus.tick, bus.pending});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_default_div();
    int ticks0, rises0;
    logic prev0;
    ticks0 = 0; rises0 = 0; prev0 = bus.clk_d[0];
    bus.en = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if ({bus.clk_d, bus.tick, bus.pending} !== {m_clk, m_tick, m_pend}) begin
        n_errors++;
        $display("FAIL default_model cyc %0d got %h want %h", k,
                 {bus.clk_d, bus.tick, bus.pending}, {m_clk, m_tick, m_pend});
      end
      if (k == 1 || k == 2) begin
        n_checks++;
        if (bus.clk_d !== ((k == 2) ? 4'hF : 4'h0)) begin
          n_errors++;
          $display("FAIL first_tc cyc %0d got %h", k, bus.clk_d);
        end
      end
      if (bus.tick[0]) ticks0++;
      if (bus.clk_d[0] && !prev0) rises0++;
      prev0 = bus.clk_d[0];
    end
    n_checks++;
    if (ticks0 != 4 || rises0 != 2) begin
      n_errors++;
      $display("FAIL default_period ticks %0d rises %0d want 4 2", ticks0, rises0);
    end
  endtask

  task automatic test_pending_load();
    int n;
    n = 0;
    while (!bus.tick[0] && n < 10) begin step(); n++; end
    n_checks++;
    if (!bus.tick[0]) begin n_errors++; $display("FAIL pend_wait got 0 want tick"); end
    bus.load = 1'b1; bus.load_mask = 4'b0001; bus.div_in = 16'd4;
    step();
    bus.load = 1'b0;
    n_checks++;
    if (bus.pending !== 4'b0001 || bus.pending !== m_pend) begin
      n_errors++; $display("FAIL pend_set got %b want 0001", bus.pending);
    end
    step();
    n_checks++;
    if (bus.pending !== 4'b0000 || bus.tick[0] !== 1'b1) begin
      n_errors++; $display("FAIL pend_clear pend %b tick0 %b want 0000 1", bus.pending, bus.tick[0]);
    end
    n = 0;
    do begin
      step(); n++;
      n_checks++;
      if ({bus.clk_d, bus.tick, bus.pending} !== {m_clk, m_tick, m_pend}) begin
        n_errors++;
        $display("FAIL pend_model got %h want %h", {bus.clk_d, bus.tick, bus.pending}, {m_clk, m_tick, m_pend});
      end
    end while (!bus.tick[0] && n < 20);
    n_checks++;
    if (n != 5) begin n_errors++; $display("FAIL pend_halfperiod got %0d want 5", n); end
  endtask

  task automatic test_tc_load();
    int n;
    n = 0;
    while (m_rem[0] != 1 && n < 20) begin step(); n++; end
    bus.load = 1'b1; bus.load_mask = 4'b0001; bus.div_in = 16'd2;
    step();
    bus.load = 1'b0;
    n_checks++;
    if (bus.pending[0] !== 1'b0 || bus.tick[0] !== 1'b1) begin
      n_errors++; $display("FAIL tc_load pend0 %b tick0 %b want 0 1", bus.pending[0], bus.tick[0]);
    end
    n = 0;
    do begin
      step(); n++;
      n_checks++;
      if (bus.pending[0] !== 1'b0 || {bus.clk_d, bus.tick} !== {m_clk, m_tick}) begin
        n_errors++;
        $display("FAIL tc_model got %h want %h", {bus.clk_d, bus.tick, bus.pending}, {m_clk, m_tick, m_pend});
      end
    end while (!bus.tick[0] && n < 20);
    n_checks++;
    if (n != 3) begin n_errors++; $display("FAIL tc_halfperiod got %0d want 3", n); end
  endtask

  task automatic test_enable_freeze();
    logic c1;
    c1 = bus.clk_d[1];
    bus.en = 4'b1101;
    for (int k = 0; k < 7; k++) begin
      step();
      n_checks++;
      if (bus.clk_d[1] !== c1 || bus.tick[1] !== 1'b0) begin
        n_errors++; $display("FAIL freeze clk1 %b tick1 %b want %b 0", bus.clk_d[1], bus.tick[1], c1);
      end
    end
    bus.en = 4'hF;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if ({bus.clk_d, bus.tick, bus.pending} !== {m_clk, m_tick, m_pend}) begin
        n_errors++;
        $display("FAIL resume_model got %h want %h", {bus.clk_d, bus.tick, bus.pending}, {m_clk, m_tick, m_pend});
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (m_rem[2] != 2 && n < 10) begin step(); n++; end
    bus.load = 1'b1; bus.load_mask = 4'b0100; bus.div_in = 16'd5;
    step();
    bus.load = 1'b0;
    n_checks++;
    if (bus.pending[2] !== 1'b1) begin n_errors++; $display("FAIL rmid_pend got %b want 1", bus.pending[2]); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({bus.clk_d, bus.tick, bus.pending} !== 12'h000) begin
      n_errors++; $display("FAIL rmid_reset got %h want 000", {bus.clk_d, bus.tick, bus.pending});
    end
    step();
    step();
    n_checks++;
    if (bus.clk_d[2] !== 1'b1 || bus.tick[2] !== 1'b1) begin
      n_errors++; $display("FAIL rmid_defdiv clk2 %b tick2 %b want 1 1", bus.clk_d[2], bus.tick[2]);
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    bus.en = '0;
    bus.load = 1'b1; bus.load_mask = 4'b0001; bus.div_in = 16'd1; step();
    bus.load_mask = 4'b0010; bus.div_in = 16'd3; step();
    bus.load = 1'b0; bus.en = 4'hF;
    repeat ($urandom_range(3, 9)) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    n_checks++;
    if (bus.clk_d[1:0] !== 2'b00 || bus.tick[1:0] !== 2'b00) begin
      n_errors++; $display("FAIL sync_zero clk %b tick %b want 00 00", bus.clk_d[1:0], bus.tick[1:0]);
    end
    for (int k = 1; k <= 24; k++) begin
      step();
      n_checks++;
      if ({bus.clk_d, bus.tick, bus.pending} !== {m_clk, m_tick, m_pend}) begin
        n_errors++;
        $display("FAIL sync_model cyc %0d got %h want %h", k, {bus.clk_d, bus.tick, bus.pending}, {m_clk, m_tick, m_pend});
      end
      if (k % 8 == 0) begin
        n_checks++;
        if (bus.clk_d[1:0] !== 2'b00 || bus.tick[1:0] !== 2'b11) begin
          n_errors++; $display("FAIL sync_align cyc %0d clk %b tick %b want 00 11", k, bus.clk_d[1:0], bus.tick[1:0]);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int c = 0; c < NCH; c++) bus.en[c] = ($urandom_range(0, 4) != 0);
      bus.load = ($urandom_range(0, 7) == 0);
      bus.load_mask = NCH'($urandom);
      bus.div_in = CW'($urandom_range(0, 6));
      bus.sync = ($urandom_range(0, 29) == 0);
      step();
      n_checks++;
      if ({bus.clk_d, bus.tick, bus.pending} !== {m_clk, m_tick, m_pend}) begin
        n_errors++;
        $display("FAIL random_model cyc %0d got %h want %h", k, {bus.clk_d, bus.tick, bus.pending}, {m_clk, m_tick, m_pend});
      end
    end
    rst_n = 1'b1; bus.load = 1'b0; bus.sync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_pending_load();
    test_tc_load();
    test_enable_freeze();
    test_reset_mid();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
